// File: rtl/chacha_sched_pkg.sv
// Shared types for the ChaCha block scheduler: FSM states, error codes, counter width.
// No logic here, so there is no latency and no backpressure.
package chacha_sched_pkg;

  localparam int CTR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    WAIT,
    EMIT,
    CLOSE
  } sched_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CTR_OVF = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ABORT   = 2'b11
  } err_code_e;

endpackage

// File: rtl/chacha_block_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted req at or after ptr, wrapping; one-hot grant plus index.
// Purely combinational (0 cycles); no backpressure, the parent registers the result.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any_req
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(ptr) + off) % N);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        winner      = cand;
      end
    end
  end

endmodule

// File: rtl/chacha_block_scheduler.sv
// Shares one ChaCha block core among NUM_REQ requesters, running N blocks per grant; ARB->core_start 1 cycle, core_done->blk_valid 1 cycle.
// Backpressure: holds START while core_busy; pending requesters wait for the current transaction to close.
module chacha_block_scheduler
  import chacha_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int BLK_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*BLK_W-1:0] req_blocks,
  input  logic [NUM_REQ*32-1:0]    req_counter,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     core_start,
  output logic [31:0]              core_counter,
  input  logic                     core_busy,
  input  logic                     core_done,
  output logic                     blk_valid,
  output logic [BLK_W-1:0]         blk_idx,
  output logic                     blk_last,
  output logic                     txn_done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic                     sched_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  sched_state_e state, state_nxt;

  logic [BLK_W-1:0] blocks_arr [NUM_REQ];
  logic [CTR_W-1:0] base_arr   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign blocks_arr[g] = req_blocks[g*BLK_W +: BLK_W];
    assign base_arr[g]   = req_counter[g*CTR_W +: CTR_W];
  end

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_winner;
  logic               arb_any;
  logic [IW-1:0]      rr_ptr;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .winner  (arb_winner),
    .any_req (arb_any)
  );

  logic [BLK_W-1:0] arb_blocks;
  logic [CTR_W-1:0] arb_base;
  logic [CTR_W:0]   arb_last_ctr;
  logic             arb_ovf;

  assign arb_blocks   = blocks_arr[arb_winner];
  assign arb_base     = base_arr[arb_winner];
  // 33-bit sum so a run that would wrap past 2^32-1 is caught up front
  assign arb_last_ctr = {1'b0, arb_base} + {{(CTR_W+1-BLK_W){1'b0}}, arb_blocks} - (CTR_W+1)'(1);
  assign arb_ovf      = arb_last_ctr[CTR_W];

  logic [IW-1:0]    win_q;
  logic [BLK_W-1:0] blocks_q;
  logic [BLK_W-1:0] idx;
  logic [TW-1:0]    timer;
  logic             is_last;

  assign is_last = (idx == blocks_q - BLK_W'(1));

  logic      ld_txn, go_start, launch, advance, close_ld;
  err_code_e close_code;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ld_txn     = 1'b0;
    go_start   = 1'b0;
    launch     = 1'b0;
    advance    = 1'b0;
    close_ld   = 1'b0;
    close_code = ERR_NONE;
    case (state)
      IDLE: if (|req) state_nxt = ARB;
      ARB: begin
        if (!arb_any) begin
          state_nxt = IDLE;
        end else begin
          ld_txn = 1'b1;
          if (arb_blocks == '0) begin
            state_nxt = CLOSE;
            close_ld  = 1'b1;
          end else if (arb_ovf) begin
            state_nxt  = CLOSE;
            close_ld   = 1'b1;
            close_code = ERR_CTR_OVF;
          end else begin
            state_nxt = START;
            go_start  = 1'b1;
          end
        end
      end
      START: begin
        if (!core_busy) begin
          launch    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (core_done) begin
          state_nxt = EMIT;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          state_nxt  = CLOSE;
          close_ld   = 1'b1;
          close_code = ERR_TIMEOUT;
        end
      end
      EMIT: begin
        if (is_last) begin
          state_nxt = CLOSE;
          close_ld  = 1'b1;
        end else if (!req[win_q]) begin
          state_nxt  = CLOSE;
          close_ld   = 1'b1;
          close_code = ERR_ABORT;
        end else begin
          state_nxt = START;
          advance   = 1'b1;
        end
      end
      CLOSE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= '0;
      rr_ptr       <= '0;
      win_q        <= '0;
      blocks_q     <= '0;
      idx          <= '0;
      timer        <= '0;
      core_counter <= '0;
      err          <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      if (ld_txn) begin
        gnt      <= arb_grant;
        win_q    <= arb_winner;
        blocks_q <= arb_blocks;
        idx      <= '0;
        rr_ptr   <= (arb_winner == IW'(NUM_REQ - 1)) ? '0 : arb_winner + IW'(1);
      end
      if (go_start) core_counter <= arb_base;
      if (advance) begin
        idx          <= idx + BLK_W'(1);
        core_counter <= core_counter + CTR_W'(1);
      end
      // timer holds the number of cycles elapsed since core_start
      if (launch)              timer <= TW'(1);
      else if (state == WAIT)  timer <= timer + TW'(1);
      if (close_ld) begin
        err      <= (close_code != ERR_NONE);
        err_code <= close_code;
      end
      if (state == CLOSE) begin
        gnt      <= '0;
        err      <= 1'b0;
        err_code <= 2'b00;
      end
    end
  end

  assign core_start = launch;
  assign blk_valid  = (state == EMIT);
  assign blk_idx    = (state == EMIT) ? idx : '0;
  assign blk_last   = (state == EMIT) && is_last;
  assign txn_done   = (state == CLOSE);
  assign sched_busy = (state != IDLE);

endmodule
